// File: rtl/uart_rx_pack_ctrl.sv
// uart_rx_pack_ctrl: drains the UART RX FIFO and packs characters LSB-first into bus words, flushing partial words on a baud-tick timeout
// Ports:
//   clk_i, rst_i        clock; asynchronous active-high reset
//   enable_i            start new FIFO reads while high (an in-flight read always completes)
//   timeout_thr_i       idle bit-periods before a partial flush, 0 disables the timeout
//   br_en_i             one-cycle baud tick
//   fifo_empty_i        RX FIFO empty flag
//   fifo_rd_en_o        one-cycle FIFO read strobe; data arrives on fifo_rd_data_i next cycle
//   word_data_o/be_o    packed word and byte-valid mask, held stable while word_vld_o is high
//   word_vld_o/rdy_i    output word handshake
//   timeout_irq_o       one-cycle pulse when a timeout flush is issued
//   word_cnt_o          wrapping count of accepted words
module uart_rx_pack_ctrl #(
    parameter int DLY        = 1,
    parameter int DATA_WIDTH = 8,
    parameter int PACK_NUM   = 4,
    parameter int TIMEOUT_W  = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             enable_i,
    input  logic [TIMEOUT_W-1:0]             timeout_thr_i,
    input  logic                             br_en_i,
    input  logic                             fifo_empty_i,
    output logic                             fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0]            fifo_rd_data_i,
    output logic [DATA_WIDTH*PACK_NUM-1:0]   word_data_o,
    output logic [PACK_NUM-1:0]              word_be_o,
    output logic                             word_vld_o,
    input  logic                             word_rdy_i,
    output logic                             timeout_irq_o,
    output logic [15:0]                      word_cnt_o
);
    localparam int SW = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;
    localparam int CW = $clog2(PACK_NUM + 1);
    typedef enum logic [1:0] {IDLE, READ, CAP, PUSH} state_t;
    state_t               state;
    logic [CW-1:0]        byte_cnt;
    logic [TIMEOUT_W-1:0] idle_cnt;
    logic [SW-1:0]        slot;
    logic                 idle_wait;
    logic                 unused_dly;
    assign slot       = byte_cnt[SW-1:0];
    // the line is idle only while a partial word waits on an empty FIFO
    assign idle_wait  = (byte_cnt != '0) && fifo_empty_i;
    assign unused_dly = |DLY;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            fifo_rd_en_o  <= 1'b0;
            word_data_o   <= '0;
            word_be_o     <= '0;
            word_vld_o    <= 1'b0;
            timeout_irq_o <= 1'b0;
            word_cnt_o    <= '0;
            byte_cnt      <= '0;
            idle_cnt      <= '0;
        end else begin
            timeout_irq_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable_i && !fifo_empty_i && byte_cnt < CW'(PACK_NUM)) begin
                        state        <= READ;
                        fifo_rd_en_o <= 1'b1;
                        idle_cnt     <= '0;
                    end else if (idle_wait && timeout_thr_i != '0 && idle_cnt >= timeout_thr_i) begin
                        state         <= PUSH;
                        word_vld_o    <= 1'b1;
                        timeout_irq_o <= 1'b1;
                        idle_cnt      <= '0;
                    end else if (idle_wait) begin
                        // saturate so a long idle never wraps back below the threshold
                        if (br_en_i && !(&idle_cnt)) idle_cnt <= idle_cnt + 1'b1;
                    end else begin
                        idle_cnt <= '0;
                    end
                end
                READ: begin
                    fifo_rd_en_o <= 1'b0;
                    state        <= CAP;
                end
                CAP: begin
                    word_data_o[slot*DATA_WIDTH +: DATA_WIDTH] <= fifo_rd_data_i;
                    word_be_o[slot] <= 1'b1;
                    byte_cnt        <= byte_cnt + 1'b1;
                    idle_cnt        <= '0;
                    state           <= (byte_cnt == CW'(PACK_NUM - 1)) ? PUSH : IDLE;
                    word_vld_o      <= (byte_cnt == CW'(PACK_NUM - 1));
                end
                PUSH: begin
                    idle_cnt <= '0;
                    if (word_rdy_i) begin
                        state       <= IDLE;
                        word_vld_o  <= 1'b0;
                        word_data_o <= '0;
                        word_be_o   <= '0;
                        byte_cnt    <= '0;
                        word_cnt_o  <= word_cnt_o + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_pack_ctrl.sv
// tb_uart_rx_pack_ctrl: directed bench with a FIFO model and a transaction-level word scoreboard
module tb_uart_rx_pack_ctrl;
    localparam int DW = 8;
    localparam int PN = 4;
    localparam int TW = 8;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            enable_i = 1'b0;
    logic [TW-1:0]   timeout_thr_i = '0;
    logic            br_en_i = 1'b0;
    logic            fifo_empty_i = 1'b1;
    logic            fifo_rd_en_o;
    logic [DW-1:0]   fifo_rd_data_i = '0;
    logic [DW*PN-1:0] word_data_o;
    logic [PN-1:0]   word_be_o;
    logic            word_vld_o;
    logic            word_rdy_i = 1'b0;
    logic            timeout_irq_o;
    logic [15:0]     word_cnt_o;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  be;
        logic        irq;
    } word_t;

    word_t      exp_q[$];
    logic [7:0] fifo_q[$];
    int         rd_at[$];
    int         checks = 0;
    int         failures = 0;
    int         irq_n = 0;
    int         cyc_n = 0;
    logic [15:0] acc = '0;
    logic       prev_vld = 1'b0;

    uart_rx_pack_ctrl #(.DLY(1), .DATA_WIDTH(DW), .PACK_NUM(PN), .TIMEOUT_W(TW)) dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .timeout_thr_i(timeout_thr_i),
        .br_en_i(br_en_i), .fifo_empty_i(fifo_empty_i), .fifo_rd_en_o(fifo_rd_en_o),
        .fifo_rd_data_i(fifo_rd_data_i), .word_data_o(word_data_o), .word_be_o(word_be_o),
        .word_vld_o(word_vld_o), .word_rdy_i(word_rdy_i), .timeout_irq_o(timeout_irq_o),
        .word_cnt_o(word_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        fifo_empty_i = 1'b0;
    endtask

    task automatic tick();
        br_en_i = 1'b1;
        cyc(1);
        br_en_i = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            cyc(1);
            n++;
        end
        chk(nm, exp_q.size(), 0);
    endtask

    task automatic wait_rd(input string nm, input int max);
        int n = 0;
        do begin
            cyc(1);
            n++;
        end while (!fifo_rd_en_o && n < max);
        chk(nm, fifo_rd_en_o, 1);
    endtask

    task automatic wait_vld(input string nm, input int max);
        int n = 0;
        do begin
            cyc(1);
            n++;
        end while (!word_vld_o && n < max);
        chk(nm, word_vld_o, 1);
    endtask

    // FIFO model: a strobe pops the head, data shows up the following cycle
    initial forever begin
        @(posedge clk);
        if (fifo_rd_en_o && fifo_q.size() != 0) begin
            fifo_rd_data_i <= fifo_q.pop_front();
            fifo_empty_i = (fifo_q.size() == 0);
        end
    end

    // scoreboard: every presented word must match the expected head; accepts drive the count
    initial forever begin
        @(negedge clk);
        cyc_n++;
        if (rst_i) begin
            chk("rst_vld", word_vld_o, 0);
            chk("rst_rd", fifo_rd_en_o, 0);
            chk("rst_cnt", word_cnt_o, 0);
            acc = '0;
            prev_vld = 1'b0;
        end else begin
            if (fifo_rd_en_o) rd_at.push_back(cyc_n);
            if (timeout_irq_o) irq_n++;
            chk("rd_in_push", fifo_rd_en_o & word_vld_o, 0);
            chk("word_cnt", word_cnt_o, acc);
            if (word_vld_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", word_data_o, 32'hDEAD_BEEF);
                end else begin
                    chk("word_data", word_data_o, exp_q[0].d);
                    chk("word_be", word_be_o, exp_q[0].be);
                    chk("word_irq", timeout_irq_o, prev_vld ? 1'b0 : exp_q[0].irq);
                    if (word_rdy_i) begin
                        void'(exp_q.pop_front());
                        acc = acc + 16'd1;
                    end
                end
            end else begin
                chk("irq_no_word", timeout_irq_o, 0);
            end
            prev_vld = word_vld_o && !word_rdy_i;
        end
    end

    initial begin
        cyc(3);
        chk("reset_data", word_data_o, 0);
        chk("reset_be", word_be_o, 0);
        chk("reset_irq", timeout_irq_o, 0);
        rst_i = 1'b0;
        cyc(2);

        // full word from four queued bytes
        enable_i = 1'b1;
        word_rdy_i = 1'b1;
        rd_at.delete();
        exp_q.push_back('{32'h4433_2211, 4'hF, 1'b0});
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_done("full_word_done", 40);
        cyc(3);
        chk("full_rd_count", rd_at.size(), 4);
        for (int i = 1; i < 4 && i < rd_at.size(); i++) chk("rd_spacing", rd_at[i] - rd_at[i-1], 3);
        chk("full_cnt", word_cnt_o, 1);
        chk("full_irq_n", irq_n, 0);

        // partial word flushed after four idle baud ticks
        timeout_thr_i = 8'd4;
        push(8'hA5); push(8'h5A);
        cyc(10);
        repeat (3) begin
            cyc(15);
            tick();
        end
        cyc(15);
        exp_q.push_back('{32'h0000_5AA5, 4'b0011, 1'b1});
        tick();
        wait_done("timeout_done", 6);
        chk("timeout_irq_n", irq_n, 1);
        chk("timeout_cnt", word_cnt_o, 2);
        timeout_thr_i = 8'd0;

        // backpressure with eight bytes queued
        word_rdy_i = 1'b0;
        exp_q.push_back('{32'h0403_0201, 4'hF, 1'b0});
        exp_q.push_back('{32'h0807_0605, 4'hF, 1'b0});
        for (int i = 1; i <= 8; i++) push(8'(i));
        cyc(40);
        chk("bp_fifo_left", fifo_q.size(), 4);
        chk("bp_vld_held", word_vld_o, 1);
        word_rdy_i = 1'b1;
        wait_done("bp_done", 40);
        chk("bp_cnt", word_cnt_o, 4);

        // timeout disabled: a lone byte survives 300 ticks
        push(8'h7E);
        cyc(6);
        br_en_i = 1'b1;
        cyc(300);
        br_en_i = 1'b0;
        chk("disabled_no_word", word_vld_o, 0);
        exp_q.push_back('{32'h0302_017E, 4'hF, 1'b0});
        push(8'h01); push(8'h02); push(8'h03);
        wait_done("disabled_done", 30);
        chk("disabled_irq_n", irq_n, 1);

        // idle counter saturates at all-ones: a threshold of 0xFF fires after 300 ticks
        push(8'h9C);
        cyc(6);
        br_en_i = 1'b1;
        cyc(300);
        br_en_i = 1'b0;
        cyc(2);
        exp_q.push_back('{32'h0000_009C, 4'b0001, 1'b1});
        timeout_thr_i = 8'hFF;
        wait_done("saturate_done", 6);
        timeout_thr_i = 8'd0;
        chk("saturate_irq_n", irq_n, 2);
        chk("saturate_cnt", word_cnt_o, 6);

        // enable dropped in the READ cycle: that byte lands, the next one stays queued
        word_rdy_i = 1'b0;
        push(8'h55); push(8'h66);
        wait_rd("en_rd_seen", 10);
        enable_i = 1'b0;
        cyc(10);
        chk("en_fifo_left", fifo_q.size(), 1);
        exp_q.push_back('{32'h8877_6655, 4'hF, 1'b0});
        enable_i = 1'b1;
        push(8'h77); push(8'h88);
        wait_vld("en_word_vld", 20);
        cyc(3);

        // asynchronous reset in the middle of a cycle while the word is held
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_vld", word_vld_o, 0);
        chk("arst_data", word_data_o, 0);
        chk("arst_be", word_be_o, 0);
        chk("arst_cnt", word_cnt_o, 0);
        chk("arst_rd", fifo_rd_en_o, 0);
        chk("arst_irq", timeout_irq_o, 0);
        exp_q.delete();
        acc = '0;
        cyc(2);
        rst_i = 1'b0;
        word_rdy_i = 1'b1;
        cyc(2);

        // preload the word counter to its last value
        force dut.word_cnt_o = 16'hFFFF;
        acc = 16'hFFFF;
        #1;
        release dut.word_cnt_o;
        cyc(1);
        chk("preload_cnt", word_cnt_o, 16'hFFFF);

        // baud tick colliding with a capture: the counter restarts from zero
        timeout_thr_i = 8'd2;
        push(8'hC3);
        cyc(6);
        tick();
        push(8'h3C);
        wait_rd("coll_rd_seen", 10);
        cyc(1);
        br_en_i = 1'b1;
        cyc(1);
        br_en_i = 1'b0;
        cyc(3);
        tick();
        cyc(6);
        chk("coll_no_early_flush", word_vld_o, 0);
        exp_q.push_back('{32'h0000_3CC3, 4'b0011, 1'b1});
        tick();
        wait_done("coll_done", 6);
        cyc(1);
        chk("wrap_cnt", word_cnt_o, 16'h0000);
        chk("coll_irq_n", irq_n, 3);
        timeout_thr_i = 8'd0;

        cyc(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
